rtc_bus_sequencer: RTL and testbench

//  Parametrised multi-channel bus sequencer for the RTC multiplexed address/data bus (A_D, CS, RD, WR).

---
 rtl/rtc_bus_sequencer_if.sv | 20 ++
 rtl/rtc_bus_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_sequencer_if.sv
// RTC multiplexed address/data bus.
//   A_D      0 = address phase, 1 = data phase
//   CS/RD/WR active-low chip select and strobes
//   bus_out  value driven onto A/D lines when bus_oe is high
//   bus_in   value sampled from A/D lines
// master: the sequencer; slave: the RTC side (or a bench model of it).
interface rtc_bus_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              A_D;
    logic              CS;
    logic              RD;
    logic              WR;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_out;
    logic [DATA_W-1:0] bus_in;

    modport master (output A_D, CS, RD, WR, bus_oe, bus_out, input bus_in);
    modport slave  (input A_D, CS, RD, WR, bus_oe, bus_out, output bus_in);
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Round-robin multi-channel burst sequencer for the RTC multiplexed A/D bus.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   req/op_rd        per-channel request and direction (1 = read)
//   addr/burst_len   per-channel start address and beats-1, packed per channel
//   wr_data          write data from the granted channel, driven after data_req
//   gnt/busy         one-hot grant for the whole burst, sequencer active
//   beat_idx         current beat within the burst
//   data_req         one-cycle request for wr_data
//   rd_data/rd_valid last read value and its update pulse
//   done/aborted     end-of-burst pulse and early-termination qualifier
//   bus              RTC bus (master modport)
//
// state    | meaning
// IDLE     | waiting for a request, arbitrate on entry of one
// ADDR_SU  | CS low, address driven, before WR
// ADDR_PW  | WR low with address
// ADDR_HD  | CS low after WR release
// GAP      | CS high, one cycle between address and data phase
// DATA_SU  | CS low, A_D high; write data requested and captured
// DATA_PW  | WR or RD low
// DATA_HD  | CS low after strobe release
// NEXT     | CS high; decide next beat or end of burst
// DONE     | done pulse, grant released
module rtc_bus_sequencer #(
    parameter int NCH     = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 4,
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           req,
    input  logic [NCH-1:0]           op_rd,
    input  logic [NCH*ADDR_W-1:0]    addr,
    input  logic [NCH*BURST_W-1:0]   burst_len,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [NCH-1:0]           gnt,
    output logic                     busy,
    output logic [BURST_W-1:0]       beat_idx,
    output logic                     data_req,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     done,
    output logic                     aborted,
    rtc_bus_sequencer_if.master      bus
);
    localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [TMR_W-1:0] TSU = TMR_W'(T_SETUP - 1);
    localparam logic [TMR_W-1:0] TPW = TMR_W'(T_PULSE - 1);
    localparam logic [TMR_W-1:0] THD = TMR_W'(T_HOLD - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_SU, S_ADDR_PW, S_ADDR_HD, S_GAP,
        S_DATA_SU, S_DATA_PW, S_DATA_HD, S_NEXT, S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [TMR_W-1:0]   tmr, tmr_nx;
    logic [PTR_W-1:0]   rr_ptr, win;
    logic [ADDR_W-1:0]  cur_addr;
    logic [BURST_W-1:0] len_q;
    logic [DATA_W-1:0]  data_q;
    logic               op_q, abort_q;
    logic               grant, advance, abort_set, load_wr, sample_rd;
    logic               a_d, cs_n, rd_n, wr_n, oe;
    logic [DATA_W-1:0]  bout;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin : arb
        int cand;
        win  = '0;
        cand = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NCH) cand = cand - NCH;
            if (req[cand]) win = PTR_W'(cand);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tmr_nx    = tmr;
        grant     = 1'b0;
        advance   = 1'b0;
        abort_set = 1'b0;
        load_wr   = 1'b0;
        sample_rd = 1'b0;
        a_d       = 1'b0;
        cs_n      = 1'b1;
        rd_n      = 1'b1;
        wr_n      = 1'b1;
        oe        = 1'b0;
        bout      = '0;
        data_req  = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant    = 1'b1;
                    state_nx = S_ADDR_SU;
                    tmr_nx   = TSU;
                end
            end
            S_ADDR_SU, S_ADDR_PW, S_ADDR_HD: begin
                cs_n = 1'b0;
                oe   = 1'b1;
                bout = DATA_W'(cur_addr);
                wr_n = (state != S_ADDR_PW);
                if (tmr != '0) begin
                    tmr_nx = tmr - 1'b1;
                end else if (state == S_ADDR_SU) begin
                    state_nx = S_ADDR_PW;
                    tmr_nx   = TPW;
                end else if (state == S_ADDR_PW) begin
                    state_nx = S_ADDR_HD;
                    tmr_nx   = THD;
                end else begin
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                state_nx = S_DATA_SU;
                tmr_nx   = TSU;
            end
            S_DATA_SU, S_DATA_PW, S_DATA_HD: begin
                a_d  = 1'b1;
                cs_n = 1'b0;
                if (!op_q) begin
                    oe   = 1'b1;
                    bout = data_q;
                end
                if (state == S_DATA_SU && !op_q) begin
                    data_req = (tmr == TSU);
                    load_wr  = (tmr == '0);
                end
                if (state == S_DATA_PW) begin
                    rd_n      = !op_q;
                    wr_n      = op_q;
                    sample_rd = op_q && (tmr == '0);
                end
                if (tmr != '0) begin
                    tmr_nx = tmr - 1'b1;
                end else if (state == S_DATA_SU) begin
                    state_nx = S_DATA_PW;
                    tmr_nx   = TPW;
                end else if (state == S_DATA_PW) begin
                    state_nx = S_DATA_HD;
                    tmr_nx   = THD;
                end else begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                // A completed last beat is a normal end even if req already dropped.
                if (beat_idx == len_q) begin
                    state_nx = S_DONE;
                end else if (!(|(req & gnt))) begin
                    abort_set = 1'b1;
                    state_nx  = S_DONE;
                end else begin
                    advance  = 1'b1;
                    state_nx = S_ADDR_SU;
                    tmr_nx   = TSU;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                aborted  = abort_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt      <= '0;
            rr_ptr   <= '0;
            op_q     <= 1'b0;
            cur_addr <= '0;
            len_q    <= '0;
            beat_idx <= '0;
            abort_q  <= 1'b0;
            data_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= sample_rd;
            if (grant) begin
                gnt      <= NCH'(1) << win;
                rr_ptr   <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
                op_q     <= op_rd[win];
                cur_addr <= addr[int'(win)*ADDR_W +: ADDR_W];
                len_q    <= burst_len[int'(win)*BURST_W +: BURST_W];
                beat_idx <= '0;
                abort_q  <= 1'b0;
            end
            if (advance) begin
                cur_addr <= cur_addr + 1'b1;
                beat_idx <= beat_idx + 1'b1;
            end
            if (abort_set) abort_q <= 1'b1;
            if (state == S_DONE) begin
                gnt      <= '0;
                beat_idx <= '0;
            end
            if (load_wr)   data_q  <= wr_data;
            if (sample_rd) rd_data <= bus.bus_in;
        end
    end

    assign bus.A_D     = a_d;
    assign bus.CS      = cs_n;
    assign bus.RD      = rd_n;
    assign bus.WR      = wr_n;
    assign bus.bus_oe  = oe;
    assign bus.bus_out = bout;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;
    localparam int NCH = 3;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int BW  = 4;

    localparam logic [1:0] K_WR   = 2'd0;
    localparam logic [1:0] K_RD   = 2'd1;
    localparam logic [1:0] K_RDV  = 2'd2;
    localparam logic [1:0] K_DONE = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    op_rd = '0;
    logic [NCH*AW-1:0] addr = '0;
    logic [NCH*BW-1:0] burst_len = '0;
    logic [DW-1:0]     wr_data = 8'hEE;
    logic [NCH-1:0]    gnt;
    logic              busy;
    logic [BW-1:0]     beat_idx;
    logic              data_req;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              done;
    logic              aborted;

    logic [7:0] rd_tab [16];
    logic [7:0] wr_tab [3][16];

    rtc_bus_sequencer_if #(.DATA_W(DW)) bus_if ();

    rtc_bus_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_rd     (op_rd),
        .addr      (addr),
        .burst_len (burst_len),
        .wr_data   (wr_data),
        .gnt       (gnt),
        .busy      (busy),
        .beat_idx  (beat_idx),
        .data_req  (data_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .aborted   (aborted),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;

    // RTC model: returns the per-beat read value for the beat in progress.
    assign bus_if.bus_in = rd_tab[beat_idx];

    typedef struct packed {
        logic [1:0] kind;
        logic       a_d;
        logic       oe;
        logic       ok;
        logic [7:0] bus;
        logic       chk_bus;
        logic [2:0] gnt;
        logic [3:0] beat;
        logic [7:0] len;
        logic       ab;
    } ev_t;

    ev_t exp_q[$];
    int  n_pass   = 0;
    int  n_checks = 0;

    function automatic int onehot_idx(input logic [2:0] g);
        int r = 0;
        for (int i = 0; i < 3; i++) if (g[i] === 1'b1) r = i;
        return r;
    endfunction

    task automatic push(input logic [1:0] kind, input logic a_d, input logic oe,
                        input logic [7:0] bv, input logic chk, input logic [2:0] g,
                        input int beat, input int len, input logic ab);
        ev_t e;
        e.kind = kind; e.a_d = a_d; e.oe = oe; e.ok = 1'b1; e.bus = bv;
        e.chk_bus = chk; e.gnt = g; e.beat = 4'(beat); e.len = 8'(len); e.ab = ab;
        exp_q.push_back(e);
    endtask

    // Expected events of a burst: per beat an address WR strobe, then either a
    // write-data WR strobe or an RD strobe followed by rd_valid; then done.
    task automatic push_burst(input int ch, input bit rd, input logic [7:0] a0,
                              input int nb, input logic ab);
        logic [2:0] g;
        logic [7:0] a;
        g = 3'b001 << ch;
        for (int b = 0; b < nb; b++) begin
            a = a0 + 8'(b);
            push(K_WR, 1'b0, 1'b1, a, 1'b1, g, b, 4, 1'b0);
            if (rd) begin
                push(K_RD, 1'b1, 1'b0, 8'h00, 1'b0, g, b, 4, 1'b0);
                push(K_RDV, 1'b0, 1'b0, rd_tab[b], 1'b1, g, b, 0, 1'b0);
            end else begin
                push(K_WR, 1'b1, 1'b1, wr_tab[ch][b], 1'b1, g, b, 4, 1'b0);
            end
        end
        push(K_DONE, 1'b0, 1'b0, 8'h00, 1'b0, g, 0, 18 * nb, ab);
    endtask

    task automatic check_ev(input ev_t a);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event kind=%0d gnt=%b bus=%h beat=%0d len=%0d ab=%b",
                     a.kind, a.gnt, a.bus, a.beat, a.len, a.ab);
        end else begin
            e = exp_q.pop_front();
            if (a.kind === e.kind && a.a_d === e.a_d && a.oe === e.oe && a.ok === e.ok &&
                (!e.chk_bus || a.bus === e.bus) && a.gnt === e.gnt && a.beat === e.beat &&
                a.len === e.len && a.ab === e.ab)
                n_pass++;
            else
                $display("FAIL event: got kind=%0d a_d=%b oe=%b ok=%b bus=%h gnt=%b beat=%0d len=%0d ab=%b, expected kind=%0d a_d=%b oe=%b ok=%b bus=%h gnt=%b beat=%0d len=%0d ab=%b",
                         a.kind, a.a_d, a.oe, a.ok, a.bus, a.gnt, a.beat, a.len, a.ab,
                         e.kind, e.a_d, e.oe, e.ok, e.bus, e.gnt, e.beat, e.len, e.ab);
        end
    endtask

    // Monitor: turns DUT bus and status activity into events for the scoreboard.
    bit         st_on = 1'b0;
    ev_t        st_ev;
    logic [2:0] prev_gnt = '0;
    int         gcyc = 0;

    always @(negedge clk) begin
        ev_t   ev;
        logic  strobe_low;
        if (reset !== 1'b1) begin
            st_on    = 1'b0;
            prev_gnt = '0;
            gcyc     = 0;
        end else begin
            strobe_low = (bus_if.WR === 1'b0) || (bus_if.RD === 1'b0);
            if (strobe_low && !st_on) begin
                st_on         = 1'b1;
                st_ev.kind    = (bus_if.WR === 1'b0) ? K_WR : K_RD;
                st_ev.a_d     = bus_if.A_D;
                st_ev.oe      = bus_if.bus_oe;
                st_ev.bus     = bus_if.bus_out;
                st_ev.chk_bus = 1'b0;
                st_ev.gnt     = gnt;
                st_ev.beat    = beat_idx;
                st_ev.len     = 8'd1;
                st_ev.ab      = 1'b0;
                st_ev.ok      = (bus_if.CS === 1'b0) && !(bus_if.WR === 1'b0 && bus_if.RD === 1'b0);
            end else if (strobe_low && st_on) begin
                st_ev.len = st_ev.len + 8'd1;
                if (bus_if.CS !== 1'b0 || bus_if.A_D !== st_ev.a_d || bus_if.bus_oe !== st_ev.oe ||
                    (st_ev.oe && bus_if.bus_out !== st_ev.bus) ||
                    (bus_if.WR === 1'b0 && bus_if.RD === 1'b0))
                    st_ev.ok = 1'b0;
            end else if (!strobe_low && st_on) begin
                st_on = 1'b0;
                check_ev(st_ev);
            end

            if (rd_valid === 1'b1) begin
                ev.kind = K_RDV; ev.a_d = 1'b0; ev.oe = 1'b0; ev.ok = 1'b1; ev.bus = rd_data;
                ev.chk_bus = 1'b0; ev.gnt = gnt; ev.beat = beat_idx; ev.len = 8'd0; ev.ab = 1'b0;
                check_ev(ev);
            end

            if (gnt !== 3'b000 && prev_gnt === 3'b000) gcyc = 0;
            else if (gnt !== 3'b000) gcyc++;
            prev_gnt = gnt;

            if (done === 1'b1) begin
                ev.kind = K_DONE; ev.a_d = 1'b0; ev.oe = 1'b0; ev.ok = 1'b1; ev.bus = 8'h00;
                ev.chk_bus = 1'b0; ev.gnt = gnt; ev.beat = 4'd0; ev.len = 8'(gcyc); ev.ab = aborted;
                check_ev(ev);
            end
        end
    end

    // Requester model: drive wr_data on data_req, hold it two cycles, then garbage.
    int wr_hold = 0;
    always @(negedge clk) begin
        if (data_req === 1'b1) begin
            wr_data = wr_tab[onehot_idx(gnt)][beat_idx];
            wr_hold = 2;
        end else if (wr_hold > 0) begin
            wr_hold--;
            if (wr_hold == 0) wr_data = 8'hEE;
        end
    end

    task automatic wait_done(input string name, input int maxc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (done !== 1'b1 && c < maxc);
        if (done !== 1'b1) begin
            n_checks++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, maxc);
        end
    endtask

    task automatic set_ch(input int ch, input bit rd, input logic [7:0] a, input int len);
        op_rd[ch] = rd;
        addr[ch*AW +: AW] = a;
        burst_len[ch*BW +: BW] = 4'(len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 16; i++) begin
            rd_tab[i] = 8'h00;
            for (int j = 0; j < 3; j++) wr_tab[j][i] = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_if.CS, bus_if.RD, bus_if.WR, bus_if.A_D, bus_if.bus_oe, bus_if.bus_out, gnt, busy,
             beat_idx, data_req, rd_valid, done, aborted, rd_data} ===
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})
            n_pass++;
        else
            $display("FAIL reset_state: CS=%b RD=%b WR=%b A_D=%b oe=%b bus=%h gnt=%b busy=%b beat=%0d dreq=%b rdv=%b done=%b ab=%b rd=%h, required 1 1 1 0 0 00 000 0 0 0 0 0 0 00",
                     bus_if.CS, bus_if.RD, bus_if.WR, bus_if.A_D, bus_if.bus_oe, bus_if.bus_out, gnt,
                     busy, beat_idx, data_req, rd_valid, done, aborted, rd_data);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single write, ch1
        wr_tab[1][0] = 8'h59;
        set_ch(1, 1'b0, 8'h02, 0);
        push_burst(1, 1'b0, 8'h02, 1, 1'b0);
        req = 3'b010;
        wait_done("t2_write", 100);
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Read burst of three, ch0
        rd_tab[0] = 8'h10; rd_tab[1] = 8'h11; rd_tab[2] = 8'h12;
        set_ch(0, 1'b1, 8'h21, 2);
        push_burst(0, 1'b1, 8'h21, 3, 1'b0);
        req = 3'b001;
        wait_done("t3_read", 200);
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Address wrap, ch2 write
        wr_tab[2][0] = 8'hA5; wr_tab[2][1] = 8'h3C;
        set_ch(2, 1'b0, 8'hFF, 1);
        push_burst(2, 1'b0, 8'hFF, 2, 1'b0);
        req = 3'b100;
        wait_done("t5_wrap", 150);
        req = 3'b000;
        repeat (3) @(negedge clk);

        // Abort: req drop during beat 2 address pulse
        for (int i = 0; i < 16; i++) rd_tab[i] = 8'h60 + 8'(i);
        set_ch(0, 1'b1, 8'h80, 7);
        push_burst(0, 1'b1, 8'h80, 3, 1'b1);
        req = 3'b001;
        c = 0;
        while (!(beat_idx === 4'd2 && bus_if.WR === 1'b0 && bus_if.A_D === 1'b0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            n_checks++;
            $display("FAIL t6_reach_beat2 timeout: beat_idx=%0d, required 2 within 200 cycles", beat_idx);
        end
        req = 3'b000;
        wait_done("t6_abort", 100);
        repeat (3) @(negedge clk);

        // Reset asserted mid DATA_PW of a write
        wr_tab[0][0] = 8'h81;
        set_ch(0, 1'b0, 8'h40, 0);
        push(K_WR, 1'b0, 1'b1, 8'h40, 1'b1, 3'b001, 0, 4, 1'b0);
        req = 3'b001;
        c = 0;
        while (!(bus_if.WR === 1'b0 && bus_if.A_D === 1'b1) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) begin
            n_checks++;
            $display("FAIL t1_reach_data_pw timeout: WR=%b A_D=%b, required 0 1", bus_if.WR, bus_if.A_D);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.WR, bus_if.CS, bus_if.RD, bus_if.bus_oe, gnt, busy, done} ===
            {1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0})
            n_pass++;
        else
            $display("FAIL t1_async_reset: WR=%b CS=%b RD=%b oe=%b gnt=%b busy=%b done=%b, required 1 1 1 0 000 0 0",
                     bus_if.WR, bus_if.CS, bus_if.RD, bus_if.bus_oe, gnt, busy, done);
        req = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (busy === 1'b0 && gnt === 3'b000 && bus_if.CS === 1'b1)
            n_pass++;
        else
            $display("FAIL t1_idle_after_reset: busy=%b gnt=%b CS=%b, required 0 000 1", busy, gnt, bus_if.CS);

        // Round robin with all requests held, pointer at ch0
        rd_tab[0] = 8'h4B;
        wr_tab[1][0] = 8'h77;
        set_ch(0, 1'b1, 8'h10, 0);
        set_ch(1, 1'b0, 8'h20, 0);
        set_ch(2, 1'b1, 8'h30, 0);
        push_burst(0, 1'b1, 8'h10, 1, 1'b0);
        push_burst(1, 1'b0, 8'h20, 1, 1'b0);
        push_burst(2, 1'b1, 8'h30, 1, 1'b0);
        push_burst(0, 1'b1, 8'h10, 1, 1'b0);
        req = 3'b111;
        wait_done("t4_rr_1", 100);
        wait_done("t4_rr_2", 100);
        wait_done("t4_rr_3", 100);
        c = 0;
        while (gnt !== 3'b001 && c < 20) begin
            @(negedge clk);
            c++;
        end
        req = 3'b000;
        wait_done("t4_rr_4", 100);

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drained: %0d expected events left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
